cpu0_issue_sched: RTL

Instruction issue scheduler for the cpu0 host core. Two requesters, a main fetch port and a debug/injection port, share one instruction path. A round-robin arbiter grants one of them per cycle into a small FIFO. The FIFO drains one instruction per cycle onto the core's `instruction`/`instr_valid` inputs, and issue stops permanently once a HALT opcode has been issued.

---
 rtl/cpu0_pkg.sv | 15 +
 rtl/cpu0_issue_sched_if.sv | 33 +++
 rtl/cpu0_sync_fifo.sv | 50 +++++
 rtl/cpu0_issue_sched.sv | 88 ++++++++
 4 files changed

// File: rtl/cpu0_pkg.sv
// Shared definitions for the cpu0 issue path: instruction width, opcodes, scheduler states.
package cpu0_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/cpu0_issue_sched_if.sv
// Request/issue bundle between the two instruction sources, the scheduler and the core.
interface cpu0_issue_sched_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    import cpu0_pkg::*;

    logic [INSTR_W-1:0]       m_instr_i;
    logic                     m_valid_i;
    logic                     m_ready_o;
    logic [INSTR_W-1:0]       d_instr_i;
    logic                     d_valid_i;
    logic                     d_ready_o;
    logic                     flush_i;
    logic [INSTR_W-1:0]       instruction_o;
    logic                     instr_valid_o;
    logic                     halted_o;
    logic [$clog2(DEPTH):0]   fifo_cnt_o;
    logic [CNT_W-1:0]         issue_cnt_o;

    modport master (
        output m_instr_i, m_valid_i, d_instr_i, d_valid_i, flush_i,
        input  m_ready_o, d_ready_o, instruction_o, instr_valid_o,
               halted_o, fifo_cnt_o, issue_cnt_o
    );

    modport slave (
        input  m_instr_i, m_valid_i, d_instr_i, d_valid_i, flush_i,
        output m_ready_o, d_ready_o, instruction_o, instr_valid_o,
               halted_o, fifo_cnt_o, issue_cnt_o
    );

endinterface

// File: rtl/cpu0_sync_fifo.sv
// Single-clock FIFO with registered occupancy; storage is deliberately left unreset.
module cpu0_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/cpu0_issue_sched.sv
// Round-robin main/debug arbiter feeding a FIFO that issues one instruction per cycle until HALT.
module cpu0_issue_sched
    import cpu0_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               pon_rst_i,
    cpu0_issue_sched_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e              state, nxt_state;
    logic                rr_ptr;
    logic                can_grant, grant_m, grant_d, push, pop, halt_pop;
    logic [INSTR_W-1:0]  wdata, head;
    logic [CW-1:0]       cnt;
    logic [INSTR_W-1:0]  instruction;
    logic                instr_valid, halted;
    logic [CNT_W-1:0]    issue_cnt;

    // rr_ptr==0 favours main; the loser only wins when the favoured port is idle.
    assign can_grant = (cnt < CW'(DEPTH)) && (state != HALTED) && !bus.flush_i;
    assign grant_m   = can_grant && bus.m_valid_i && (!rr_ptr || !bus.d_valid_i);
    assign grant_d   = can_grant && bus.d_valid_i && ( rr_ptr || !bus.m_valid_i);
    assign push      = grant_m || grant_d;
    assign wdata     = grant_m ? bus.m_instr_i : bus.d_instr_i;
    assign pop       = (state == RUN) && !bus.flush_i;
    assign halt_pop  = pop && (head[15:12] == OP_HALT);

    // Once halted the queue is frozen, so flush must not reach the FIFO either.
    cpu0_sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (pon_rst_i),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush_i && (state != HALTED)),
        .wdata (wdata),
        .head  (head),
        .count (cnt)
    );

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE:    if (push) nxt_state = RUN;
            RUN: begin
                if (halt_pop)                             nxt_state = HALTED;
                else if (pop && !push && cnt == CW'(1))   nxt_state = IDLE;
            end
            HALTED:  nxt_state = HALTED;
            default: nxt_state = IDLE;
        endcase
        if (bus.flush_i && state != HALTED) nxt_state = IDLE;
    end

    always_ff @(posedge clk or posedge pon_rst_i) begin
        if (pon_rst_i) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            issue_cnt   <= '0;
        end else begin
            state       <= nxt_state;
            instr_valid <= pop;
            if (pop) begin
                instruction <= head;
                issue_cnt   <= issue_cnt + CNT_W'(1);
            end
            if (nxt_state == HALTED) halted <= 1'b1;
            if (grant_m)      rr_ptr <= 1'b1;
            else if (grant_d) rr_ptr <= 1'b0;
        end
    end

    assign bus.m_ready_o     = grant_m;
    assign bus.d_ready_o     = grant_d;
    assign bus.instruction_o = instruction;
    assign bus.instr_valid_o = instr_valid;
    assign bus.halted_o      = halted;
    assign bus.fifo_cnt_o    = cnt;
    assign bus.issue_cnt_o   = issue_cnt;

endmodule
